// File: rtl/pipeline_run_controller.sv
// Run/step/halt controller for a pipelined core, driven by a debug host command port.
// Optional cycle counter is built when PIPELINE_CYCLE_COUNT_EN is defined.
module pipeline_run_controller #(
    parameter int unsigned NB           = 32,
    parameter int unsigned NB_COUNT     = 32,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    output logic                o_cmd_ready,
    input  logic [NB-1:0]       i_instruction,
    output logic                o_pipe_enable,
    output logic                o_pc_enable,
    output logic                o_flush_if,
    output logic                o_halted,
    output logic [NB_COUNT-1:0] o_cycle_count
);

    localparam int unsigned DRAIN_W     = 4;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;
    localparam logic [1:0]  CMD_RUN     = 2'b01;
    localparam logic [1:0]  CMD_STEP    = 2'b10;
    localparam logic [1:0]  CMD_STOP    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DRAIN,
        S_HALTED
    } state_e;

    state_e               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 halted_q;

    logic                 cmd_ready_c;
    logic                 cmd_fire_c;
    logic                 halt_det_c;
    logic                 pipe_en_c;
    logic                 pc_en_c;
    logic                 flush_c;
    logic                 unused_instr;

    assign unused_instr = ^i_instruction[25:0];

    assign cmd_ready_c = (state_q == S_IDLE) || (state_q == S_RUN);
    assign cmd_fire_c  = i_cmd_valid && cmd_ready_c;
    assign halt_det_c  = ((state_q == S_RUN) || (state_q == S_STEP)) &&
                         (i_instruction[31:26] == HALT_OPCODE);

    // Next-state and per-state outputs; HALT outranks any command in the same cycle.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        pipe_en_c = 1'b0;
        pc_en_c   = 1'b0;
        flush_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire_c && (i_cmd == CMD_RUN)) begin
                    state_d = S_RUN;
                end else if (cmd_fire_c && (i_cmd == CMD_STEP)) begin
                    state_d = S_STEP;
                end
            end
            S_RUN, S_STEP: begin
                pipe_en_c = 1'b1;
                pc_en_c   = !halt_det_c;
                flush_c   = halt_det_c;
                if (halt_det_c) begin
                    state_d = S_DRAIN;
                    drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
                end else if (state_q == S_STEP) begin
                    state_d = S_IDLE;
                end else if (cmd_fire_c && (i_cmd == CMD_STOP)) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                pipe_en_c = 1'b1;
                flush_c   = 1'b1;
                if (drain_q == '0) begin
                    state_d = S_HALTED;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            drain_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            halted_q <= (state_d == S_HALTED);
        end
    end

    assign o_cmd_ready   = cmd_ready_c;
    assign o_pipe_enable = pipe_en_c;
    assign o_pc_enable   = pc_en_c;
    assign o_flush_if    = flush_c;
    assign o_halted      = halted_q;

`ifdef PIPELINE_CYCLE_COUNT_EN
    logic [NB_COUNT-1:0] count_q, count_d;

    // Saturating count of enabled pipeline cycles.
    always_comb begin
        count_d = count_q;
        if (pipe_en_c && (count_q != '1)) begin
            count_d = count_q + NB_COUNT'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_cycle_count = count_q;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Scoreboard bench for pipeline_run_controller: a behavioural model pushes expected outputs
// per cycle and they are popped and compared at the falling edge.
module tb_pipeline_run_controller;

    localparam int unsigned DC = 4;
`ifdef PIPELINE_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [1:0]  NOP  = 2'b00;
    localparam logic [1:0]  RUN  = 2'b01;
    localparam logic [1:0]  STEP = 2'b10;
    localparam logic [1:0]  STOP = 2'b11;
    localparam logic [31:0] INS_ADD  = 32'h0000_0020;
    localparam logic [31:0] INS_HALT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [31:0] instr = '0;
    logic        cmd_ready, pipe_en, pc_en, flush, halted;
    logic [31:0] count;
    logic        cmd_ready4, pipe_en4, pc_en4, flush4, halted4;
    logic [3:0]  count4;

    always #5 clk = ~clk;

    pipeline_run_controller #(.NB(32), .NB_COUNT(32), .DRAIN_CYCLES(DC)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(cmd_ready), .i_instruction(instr), .o_pipe_enable(pipe_en),
        .o_pc_enable(pc_en), .o_flush_if(flush), .o_halted(halted), .o_cycle_count(count)
    );

    pipeline_run_controller #(.NB(32), .NB_COUNT(4), .DRAIN_CYCLES(DC)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(cmd_ready4), .i_instruction(instr), .o_pipe_enable(pipe_en4),
        .o_pc_enable(pc_en4), .o_flush_if(flush4), .o_halted(halted4), .o_cycle_count(count4)
    );

    typedef struct {
        logic        pipe;
        logic        pc;
        logic        flush;
        logic        halted;
        logic        ready;
        logic [31:0] count;
        logic [3:0]  count4;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: 0 idle, 1 run, 2 step, 3 drain, 4 halted
    int          m_state;
    int          m_left;
    longint      m_count;
    int          m_count4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic hd;
        hd       = ((m_state == 1) || (m_state == 2)) && (instr[31:26] == 6'h3F);
        e.pipe   = (m_state == 1) || (m_state == 2) || (m_state == 3);
        e.pc     = ((m_state == 1) || (m_state == 2)) && !hd;
        e.flush  = (m_state == 3) || hd;
        e.halted = (m_state == 4);
        e.ready  = (m_state == 0) || (m_state == 1);
        e.count  = CNT_EN ? 32'(m_count) : 32'd0;
        e.count4 = CNT_EN ? 4'(m_count4) : 4'd0;
        return e;
    endfunction

    task automatic model_edge();
        logic hd;
        logic acc;
        hd  = ((m_state == 1) || (m_state == 2)) && (instr[31:26] == 6'h3F);
        acc = cmd_valid && ((m_state == 0) || (m_state == 1));
        if ((m_state >= 1) && (m_state <= 3)) begin
            if (m_count < 64'hFFFF_FFFF) m_count++;
            if (m_count4 < 15) m_count4++;
        end
        case (m_state)
            0: if (acc && cmd == RUN) m_state = 1; else if (acc && cmd == STEP) m_state = 2;
            1: if (hd) begin m_state = 3; m_left = DC; end
               else if (acc && cmd == STOP) m_state = 0;
            2: if (hd) begin m_state = 3; m_left = DC; end else m_state = 0;
            3: begin m_left--; if (m_left == 0) m_state = 4; end
            default: ;
        endcase
    endtask

    task automatic compare_all(input exp_t e, input string pfx);
        check({pfx, "_pipe"},   32'(pipe_en),   32'(e.pipe));
        check({pfx, "_pc"},     32'(pc_en),     32'(e.pc));
        check({pfx, "_flush"},  32'(flush),     32'(e.flush));
        check({pfx, "_halted"}, 32'(halted),    32'(e.halted));
        check({pfx, "_ready"},  32'(cmd_ready), 32'(e.ready));
        check({pfx, "_count"},  count,          e.count);
        check({pfx, "_count4"}, 32'(count4),    32'(e.count4));
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic cyc(input logic v, input logic [1:0] c, input logic [31:0] ins);
        exp_t e;
        cmd_valid = v;
        cmd       = c;
        instr     = ins;
        sb_q.push_back(model_out());
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            compare_all(e, "cyc");
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        exp_t e;
        rst_n = 1'b0;
        #1;
        m_state = 0; m_left = 0; m_count = 0; m_count4 = 0;
        e = model_out();
        compare_all(e, "rst");
        cmd_valid = 1'b0;
        cmd       = NOP;
        instr     = INS_ADD;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        do_reset();

        // Run with a plain instruction for 10 cycles
        cyc(1'b1, RUN, INS_ADD);
        for (int i = 0; i < 10; i++) cyc(1'b0, NOP, INS_ADD);
        check("s1_count", count, CNT_EN ? 32'd10 : 32'd0);

        // HALT in RUN, drain, then absorbing HALTED ignores commands
        cyc(1'b0, NOP, INS_HALT);
        for (int i = 0; i < DC; i++) cyc(1'b0, NOP, INS_ADD);
        for (int i = 0; i < 3; i++) cyc(1'b1, RUN, INS_ADD);
        check("s2_halted", 32'(halted), 32'd1);

        // Three single steps from IDLE spaced 3 cycles apart
        do_reset();
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, STEP, INS_ADD);
            cyc(1'b0, NOP, INS_ADD);
            cyc(1'b0, NOP, INS_ADD);
        end
        check("s3_count", count, CNT_EN ? 32'd3 : 32'd0);

        // STOP and HALT on the same RUN cycle: HALT wins
        cyc(1'b1, RUN, INS_ADD);
        cyc(1'b1, STEP, INS_ADD);
        cyc(1'b1, STOP, INS_HALT);
        for (int i = 0; i < DC + 2; i++) cyc(1'b1, RUN, INS_ADD);

        // Reset during the second DRAIN cycle, then run again
        do_reset();
        cyc(1'b1, RUN, INS_ADD);
        cyc(1'b0, NOP, INS_HALT);
        cyc(1'b0, NOP, INS_ADD);
        do_reset();
        cyc(1'b1, RUN, INS_ADD);
        for (int i = 0; i < 10; i++) cyc(1'b0, NOP, INS_ADD);
        check("s5_count", count, CNT_EN ? 32'd10 : 32'd0);

        // 20 enabled cycles saturate the 4-bit counter
        for (int i = 0; i < 10; i++) cyc(1'b0, NOP, INS_ADD);
        check("s6_count4", 32'(count4), CNT_EN ? 32'd15 : 32'd0);
        check("s6_count32", count, CNT_EN ? 32'd20 : 32'd0);

        // STOP from RUN returns to IDLE; STEP with HALT enters DRAIN
        cyc(1'b1, STOP, INS_ADD);
        cyc(1'b1, STEP, INS_ADD);
        cyc(1'b0, NOP, INS_HALT);
        for (int i = 0; i < DC + 1; i++) cyc(1'b0, NOP, INS_ADD);

        // Random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom();
            if ($urandom_range(0, 15) != 0) ins[31] = 1'b0;
            else ins[31:26] = 6'h3F;
            if ($urandom_range(0, 60) == 0) do_reset();
            else cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ins);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
